// File: rtl/sockit_pack.sv
// Width packer: gathers NW consecutive DW-bit words into one NW*DW word, LSB-first.
// Assembly and output registers form a double buffer so filling continues while output waits.
module sockit_pack #(
  parameter int DW = 8,
  parameter int NW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    ffi_bus,
  input  logic             ffi_req,
  output logic             ffi_grt,
  output logic [NW*DW-1:0] ffo_bus,
  output logic             ffo_req,
  input  logic             ffo_grt
);

  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  logic [CW-1:0]         cnt;
  logic [(NW-1)*DW-1:0]  asm;
  logic                  ffi_trn;
  logic                  ffo_trn;
  logic                  last;

  assign last    = (cnt == LAST);
  assign ffi_grt = ~last | ~ffo_req | ffo_grt;
  assign ffi_trn = ffi_req & ffi_grt;
  assign ffo_trn = ffo_req & ffo_grt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      asm     <= '0;
      ffo_bus <= '0;
      ffo_req <= 1'b0;
    end else begin
      if (ffi_trn && !last) begin
        for (int k = 0; k < NW - 1; k++) begin
          if (cnt == CW'(k)) asm[k*DW +: DW] <= ffi_bus;
        end
        cnt <= cnt + 1'b1;
      end
      // a completing word wins over a drain, so back-to-back groups never bubble
      if (ffi_trn && last) begin
        ffo_bus <= {ffi_bus, asm};
        ffo_req <= 1'b1;
        cnt     <= '0;
      end else if (ffo_trn) begin
        ffo_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sockit_pack.sv
// Directed and randomized checks for sockit_pack with NW=4 and NW=2 instances.
// Inputs change on the falling edge; outputs are checked before the next rising edge.
module tb_sockit_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ffi_bus;
  logic        ffi_req;
  logic        ffi_grt;
  logic [31:0] ffo_bus;
  logic        ffo_req;
  logic        ffo_grt;

  logic [7:0]  ffi_bus2;
  logic        ffi_req2;
  logic        ffi_grt2;
  logic [15:0] ffo_bus2;
  logic        ffo_req2;
  logic        ffo_grt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sockit_pack #(.DW(8), .NW(4)) dut (
    .clk(clk), .rst(rst),
    .ffi_bus(ffi_bus), .ffi_req(ffi_req), .ffi_grt(ffi_grt),
    .ffo_bus(ffo_bus), .ffo_req(ffo_req), .ffo_grt(ffo_grt)
  );

  sockit_pack #(.DW(8), .NW(2)) dut2 (
    .clk(clk), .rst(rst),
    .ffi_bus(ffi_bus2), .ffi_req(ffi_req2), .ffi_grt(ffi_grt2),
    .ffo_bus(ffo_bus2), .ffo_req(ffo_req2), .ffo_grt(ffo_grt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    ffi_req = 1'b1;
    ffi_bus = w;
    @(negedge clk);
  endtask

  logic [7:0]  in_cnt;
  logic [7:0]  b;
  logic [31:0] exp_w;
  logic [31:0] prev_bus;
  logic        prev_hold;
  int          out_idx;
  int          cyc;

  initial begin
    rst = 1'b1;
    ffi_bus = '0; ffi_req = 1'b0; ffo_grt = 1'b0;
    ffi_bus2 = '0; ffi_req2 = 1'b0; ffo_grt2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(ffo_req), 32'd0);
    chk("rst_bus", ffo_bus, 32'd0);
    chk("rst_grt", 32'(ffi_grt), 32'd1);
    rst = 1'b0;

    // basic group with output always granted
    ffo_grt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ffi_req = 1'b1;
      ffi_bus = 8'(i + 1);
      #1 chk("t1_grt", 32'(ffi_grt), 32'd1);
      @(negedge clk);
    end
    ffi_req = 1'b0;
    chk("t1_req", 32'(ffo_req), 32'd1);
    chk("t1_bus", ffo_bus, 32'h04030201);
    @(negedge clk);
    chk("t1_drain", 32'(ffo_req), 32'd0);

    // NW=2 streaming: one output every two cycles, grant never drops
    ffi_req2 = 1'b1;
    ffo_grt2 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      ffi_bus2 = 8'(e - 1);
      #1 chk("nw2_grt", 32'(ffi_grt2), 32'd1);
      @(negedge clk);
      chk("nw2_req", 32'(ffo_req2), 32'((e % 2) == 0));
      if ((e % 2) == 0)
        chk("nw2_bus", 32'(ffo_bus2), 32'({8'(e - 1), 8'(e - 2)}));
    end
    ffi_req2 = 1'b0;

    // back-pressure: asm fills behind a held output word
    ffo_grt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ffi_req = 1'b1;
      ffi_bus = 8'h10 + 8'(i);
      #1 chk("t2_grt", 32'(ffi_grt), 32'd1);
      @(negedge clk);
    end
    chk("t2_req", 32'(ffo_req), 32'd1);
    chk("t2_bus", ffo_bus, 32'h13121110);
    ffi_bus = 8'h17;
    #1 chk("t2_stall", 32'(ffi_grt), 32'd0);
    @(negedge clk);
    chk("t2_hold_req", 32'(ffo_req), 32'd1);
    chk("t2_hold_bus", ffo_bus, 32'h13121110);
    ffo_grt = 1'b1;
    #1 chk("t2_grt_open", 32'(ffi_grt), 32'd1);
    chk("t2_xfer_bus", ffo_bus, 32'h13121110);
    @(negedge clk);
    ffi_req = 1'b0;
    ffo_grt = 1'b0;
    chk("t2_next_req", 32'(ffo_req), 32'd1);
    chk("t2_next_bus", ffo_bus, 32'h17161514);
    ffo_grt = 1'b1;
    @(negedge clk);
    chk("t2_drain", 32'(ffo_req), 32'd0);

    // reset mid-group discards partial words
    push(8'hAA);
    push(8'hBB);
    ffi_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(i + 1));
    ffi_req = 1'b0;
    chk("t3_req", 32'(ffo_req), 32'd1);
    chk("t3_bus", ffo_bus, 32'h04030201);
    @(negedge clk);

    // asynchronous reset drops a pending output word
    ffo_grt = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    ffi_req = 1'b0;
    chk("t4_pend_req", 32'(ffo_req), 32'd1);
    chk("t4_pend_bus", ffo_bus, 32'h24232221);
    #2 rst = 1'b1;
    #1 chk("t4_async_req", 32'(ffo_req), 32'd0);
    chk("t4_async_bus", ffo_bus, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("t4_rel_grt", 32'(ffi_grt), 32'd1);
    @(negedge clk);
    chk("t4_rel_req", 32'(ffo_req), 32'd0);

    // random handshakes on both sides, incrementing byte stream
    in_cnt = '0;
    out_idx = 0;
    cyc = 0;
    prev_hold = 1'b0;
    prev_bus = '0;
    while (out_idx < 64 && cyc < 4000) begin
      ffi_req = 1'($urandom % 2);
      ffo_grt = 1'($urandom % 2);
      ffi_bus = in_cnt;
      #1;
      if (prev_hold) begin
        chk("rnd_stable_req", 32'(ffo_req), 32'd1);
        chk("rnd_stable_bus", ffo_bus, prev_bus);
      end
      if (ffo_req && ffo_grt) begin
        b = 8'(out_idx * 4);
        exp_w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
        chk("rnd_word", ffo_bus, exp_w);
        out_idx++;
      end
      if (ffi_req && ffi_grt) in_cnt = in_cnt + 8'd1;
      prev_hold = ffo_req && !ffo_grt;
      prev_bus = ffo_bus;
      @(negedge clk);
      cyc++;
    end
    chk("rnd_done", 32'(out_idx), 32'd64);
    ffi_req = 1'b0;
    ffo_grt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
